// File: rtl/qpp_index_gen.sv
// qpp_index_gen
//   Generates the quadratic permutation polynomial interleaver sequence
//   pi(i) = (f1*i + f2*i^2) mod K for i = 0 .. K-1, one index per cycle,
//   using only modular additions (no multipliers, no dividers).
//
//   The second-order difference of pi(i) is constant, so two running sums suffice:
//     index(i+1) = index(i) + g(i)   mod K
//     g(i+1)     = g(i)     + d      mod K
//   with g(0) = f1 + f2 mod K and d = 2*f2 mod K.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_valid  configuration offered (sampled in IDLE only)
//   cfg_ready  high while IDLE
//   cfg_k      block length K (2 .. 2^K_WIDTH-1)
//   cfg_f1     QPP linear coefficient, must be < K
//   cfg_f2     QPP quadratic coefficient, must be < K
//   abort      synchronous cancel of the running block
//   out_index  pi(i)
//   out_count  i
//   out_valid  beat available
//   out_ready  consumer accepts the beat
//   out_last   beat with i = K-1
//   done       one-cycle pulse after the out_last transfer
//   cfg_err    one-cycle pulse after a rejected configuration
//
// States
//   state    | meaning
//   ST_IDLE  | waiting for a configuration, cfg_ready high
//   ST_RUN   | streaming indices, out_valid high

module qpp_index_gen #(
  parameter int K_WIDTH = 13,
  parameter int F_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [K_WIDTH-1:0] cfg_k,
  input  logic [F_WIDTH-1:0] cfg_f1,
  input  logic [F_WIDTH-1:0] cfg_f2,
  input  logic               abort,
  output logic [K_WIDTH-1:0] out_index,
  output logic [K_WIDTH-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Common width for comparing coefficients against K regardless of which is wider.
  localparam int CW = (K_WIDTH > F_WIDTH) ? K_WIDTH : F_WIDTH;

  // Modular add for operands already reduced below m: one wide add, one
  // conditional subtract. A sum equal to m folds to zero.
  function automatic logic [K_WIDTH-1:0] mod_add(
    input logic [K_WIDTH-1:0] a,
    input logic [K_WIDTH-1:0] b,
    input logic [K_WIDTH-1:0] m
  );
    logic [K_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      sum = sum - {1'b0, m};
    end
    return sum[K_WIDTH-1:0];
  endfunction

  logic [0:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] k_m1_q, k_m1_d;
  logic [K_WIDTH-1:0] g_q, g_d;
  logic [K_WIDTH-1:0] dlt_q, dlt_d;
  logic [K_WIDTH-1:0] idx_q, idx_d;
  logic [K_WIDTH-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [CW-1:0]      k_ext;
  logic [CW-1:0]      f1_ext;
  logic [CW-1:0]      f2_ext;
  logic [K_WIDTH-1:0] f1_k;
  logic [K_WIDTH-1:0] f2_k;
  logic               cfg_bad;
  logic               is_last;

  assign k_ext  = CW'(cfg_k);
  assign f1_ext = CW'(cfg_f1);
  assign f2_ext = CW'(cfg_f2);

  // Only meaningful once cfg_bad is clear, at which point both fit in K_WIDTH.
  assign f1_k = f1_ext[K_WIDTH-1:0];
  assign f2_k = f2_ext[K_WIDTH-1:0];

  assign cfg_bad = (cfg_k < K_WIDTH'(2)) || (f1_ext >= k_ext) || (f2_ext >= k_ext);

  // K-1 is stored at accept so the last-beat compare is a plain equality.
  assign is_last = (cnt_q == k_m1_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    k_m1_d  = k_m1_q;
    g_d     = g_q;
    dlt_d   = dlt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is deliberately ignored here, so a simultaneous cfg_valid wins.
        if (cfg_valid) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            k_d     = cfg_k;
            k_m1_d  = cfg_k - K_WIDTH'(1);
            g_d     = mod_add(f1_k, f2_k, cfg_k);
            dlt_d   = mod_add(f2_k, f2_k, cfg_k);
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          idx_d = mod_add(idx_q, g_q, k_q);
          g_d   = mod_add(g_q, dlt_q, k_q);
          cnt_d = cnt_q + K_WIDTH'(1);
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      k_m1_q  <= '0;
      g_q     <= '0;
      dlt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      k_m1_q  <= k_m1_d;
      g_q     <= g_d;
      dlt_q   <= dlt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Everything below is derived from reset-cleared registers, so outputs
  // reach their reset values as soon as rst_n falls.
  assign cfg_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RUN);
  assign out_last  = (state_q == ST_RUN) && is_last;
  assign out_index = idx_q;
  assign out_count = cnt_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule
